// File: rtl/mfp_sound_pkg.sv
// rtl/mfp_sound_pkg.sv - shared register map constants and channel state type for the sound block
package mfp_sound_pkg;

    // Word offsets within the sound window (HADDR[10:2])
    localparam int SND_OFF_W      = 9;
    localparam int SND_OFF_MUSIC  = 0;
    localparam int SND_OFF_VOLUME = 1;
    localparam int SND_OFF_SFX0   = 2;

    // Bit positions of the fields inside an effect-channel write word
    localparam int SND_ID_LSB  = 8;
    localparam int SND_DUR_LSB = 0;

    // Default field widths of an effect channel
    localparam int SND_ID_W  = 4;
    localparam int SND_DUR_W = 8;

    // Per-channel state at the default widths: effect ID and remaining tick count
    typedef struct packed {
        logic [SND_ID_W-1:0]  id;
        logic [SND_DUR_W-1:0] count;
    } sfx_state_t;

endpackage

// File: rtl/mfp_sound_sfx_channel.sv
// rtl/mfp_sound_sfx_channel.sv - one sound-effect channel: ID, start pulse, tick countdown
module mfp_sound_sfx_channel #(
    parameter int ID_W  = 4,
    parameter int DUR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             tick,
    input  logic [ID_W-1:0]  load_id,
    input  logic [DUR_W-1:0] load_dur,
    output logic             active,
    output logic             start,
    output logic [ID_W-1:0]  id,
    output logic [DUR_W-1:0] count
);

    // A channel is playing exactly while it has ticks left, so expiry and stop share one edge
    assign active = (count != '0);

    // Load wins over a coincident tick; an idle channel never decrements, so the count cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id    <= '0;
            count <= '0;
            start <= 1'b0;
        end else begin
            start <= 1'b0;
            if (load) begin
                id    <= load_id;
                count <= load_dur;
                start <= (load_dur != '0);
            end else if (tick && (count != '0)) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mfp_sound_ctrl_regs.sv
// rtl/mfp_sound_ctrl_regs.sv - AHB-snooped sound control registers (optional SOUND_READBACK_EN)
`ifndef H_SOUND_ADDR_Match
`define H_SOUND_ADDR_Match 9'h101
`endif

module mfp_sound_ctrl_regs
    import mfp_sound_pkg::*;
#(
    parameter int               NUM_CH    = 4,
    parameter int               ID_W      = 4,
    parameter int               DUR_W     = 8,
    parameter int               VOL_W     = 4,
    parameter logic [VOL_W-1:0] VOL_RESET = '1,
    parameter int               TICK_DIV  = 50000
) (
    input  logic                   CLK,
    input  logic                   HRESETn,
    input  logic [31:0]            HADDR,
    input  logic [31:0]            HWDATA,
    input  logic                   HWRITE,
    input  logic [1:0]             HTRANS,
    output logic                   SOUND_MUSIC_EN,
    output logic [VOL_W-1:0]       SOUND_VOLUME,
    output logic [NUM_CH-1:0]      SFX_ACTIVE,
    output logic [NUM_CH-1:0]      SFX_START,
    output logic [NUM_CH*ID_W-1:0] SFX_ID
`ifdef SOUND_READBACK_EN
    ,
    output logic [31:0]            HRDATA
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic                     addr_sel;
    logic                     dp_sel;
    logic                     dp_write;
    logic [SND_OFF_W-1:0]     dp_off;
    logic                     wr_en;
    logic [PW-1:0]            presc;
    logic                     tick;
    logic [NUM_CH*DUR_W-1:0]  ch_count;
    logic                     unused_bits;

    assign addr_sel = (HADDR[28:20] ==? `H_SOUND_ADDR_Match) && HTRANS[1];
    assign wr_en    = dp_sel && dp_write;
    assign tick     = (presc == TICK_LAST);

    // Capture the address phase so the write can commit with HWDATA one cycle later
    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_sel   <= 1'b0;
            dp_write <= 1'b0;
            dp_off   <= '0;
        end else begin
            dp_sel   <= addr_sel;
            dp_write <= HWRITE;
            dp_off   <= HADDR[10:2];
        end
    end

    // Free-running duration prescaler; tick is its terminal count
    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Music enable and master volume registers
    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            SOUND_MUSIC_EN <= 1'b0;
            SOUND_VOLUME   <= VOL_RESET;
        end else if (wr_en) begin
            if (dp_off == SND_OFF_W'(SND_OFF_MUSIC)) begin
                SOUND_MUSIC_EN <= (HWDATA != '0);
            end
            if (dp_off == SND_OFF_W'(SND_OFF_VOLUME)) begin
                SOUND_VOLUME <= HWDATA[VOL_W-1:0];
            end
        end
    end

    genvar n;
    generate
        for (n = 0; n < NUM_CH; n++) begin : g_ch
            logic ch_load;
            assign ch_load = wr_en && (dp_off == SND_OFF_W'(SND_OFF_SFX0 + n));

            mfp_sound_sfx_channel #(
                .ID_W  (ID_W),
                .DUR_W (DUR_W)
            ) u_ch (
                .clk      (CLK),
                .rst_n    (HRESETn),
                .load     (ch_load),
                .tick     (tick),
                .load_id  (HWDATA[SND_ID_LSB +: ID_W]),
                .load_dur (HWDATA[SND_DUR_LSB +: DUR_W]),
                .active   (SFX_ACTIVE[n]),
                .start    (SFX_START[n]),
                .id       (SFX_ID[n*ID_W +: ID_W]),
                .count    (ch_count[n*DUR_W +: DUR_W])
            );
        end
    endgenerate

`ifdef SOUND_READBACK_EN
    // Read mux driven during the data phase of a selected read
    always_comb begin
        HRDATA = '0;
        if (dp_sel && !dp_write) begin
            if (dp_off == SND_OFF_W'(SND_OFF_MUSIC)) begin
                HRDATA[0] = SOUND_MUSIC_EN;
            end else if (dp_off == SND_OFF_W'(SND_OFF_VOLUME)) begin
                HRDATA[VOL_W-1:0] = SOUND_VOLUME;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (dp_off == SND_OFF_W'(SND_OFF_SFX0 + i)) begin
                        HRDATA[SND_ID_LSB +: ID_W]   = SFX_ID[i*ID_W +: ID_W];
                        HRDATA[SND_DUR_LSB +: DUR_W] = ch_count[i*DUR_W +: DUR_W];
                    end
                end
            end
        end
    end

    assign unused_bits = ^{HADDR[31:29], HADDR[19:11], HADDR[1:0], HTRANS[0]};
`else
    assign unused_bits = ^{HADDR[31:29], HADDR[19:11], HADDR[1:0], HTRANS[0], ch_count};
`endif

endmodule

// File: tb/tb_mfp_sound_ctrl_regs.sv
// tb/tb_mfp_sound_ctrl_regs.sv - self-checking bench for mfp_sound_ctrl_regs (TICK_DIV=4)
`timescale 1ns/1ps
module tb_mfp_sound_ctrl_regs;

    localparam int NUM_CH = 4;
    localparam int TDIV   = 4;
    localparam logic [31:0] BASE = 32'h1010_0000;

    logic        CLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic        SOUND_MUSIC_EN;
    logic [3:0]  SOUND_VOLUME;
    logic [3:0]  SFX_ACTIVE;
    logic [3:0]  SFX_START;
    logic [15:0] SFX_ID;
`ifdef SOUND_READBACK_EN
    logic [31:0] HRDATA;
`endif

    mfp_sound_ctrl_regs #(
        .NUM_CH    (NUM_CH),
        .ID_W      (4),
        .DUR_W     (8),
        .VOL_W     (4),
        .VOL_RESET (4'hF),
        .TICK_DIV  (TDIV)
    ) dut (
        .CLK            (CLK),
        .HRESETn        (HRESETn),
        .HADDR          (HADDR),
        .HWDATA         (HWDATA),
        .HWRITE         (HWRITE),
        .HTRANS         (HTRANS),
        .SOUND_MUSIC_EN (SOUND_MUSIC_EN),
        .SOUND_VOLUME   (SOUND_VOLUME),
        .SFX_ACTIVE     (SFX_ACTIVE),
        .SFX_START      (SFX_START),
        .SFX_ID         (SFX_ID)
`ifdef SOUND_READBACK_EN
        ,
        .HRDATA         (HRDATA)
`endif
    );

    always #5 CLK = ~CLK;

    // Edge index since reset release; the prescaler ticks on edges where edge_cnt % TDIV == 0
    int edge_cnt;
    always @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] wdata;
        logic        music;
        logic [3:0]  vol;
        logic [3:0]  active;
        logic [3:0]  start;
        logic [15:0] id;
    } vec_t;

    vec_t vecs[14];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] a_off(input int off);
        return BASE | (32'(off) << 2);
    endfunction

    // Cycles from a load at edge e until a dur-tick countdown clears ACTIVE
    function automatic int exp_fall(input int e, input int dur);
        int k = e;
        int n = 0;
        while (n < dur) begin
            k++;
            if (k % TDIV == 0) n++;
        end
        return k - e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One non-pipelined transfer; returns #1 after the edge that ends the data phase
    task automatic ahb_xfer(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [31:0] d);
        @(negedge CLK);
        HADDR = a; HTRANS = t; HWRITE = w;
        @(negedge CLK);
        HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic measure(input int ch, input int exp_cyc, input string nm);
        int c = 0;
        while (c < 40 && SFX_ACTIVE[ch] === 1'b1) begin
            @(posedge CLK);
            #1;
            c++;
        end
        chk(nm, 32'(c), 32'(exp_cyc));
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_music"},  32'(SOUND_MUSIC_EN), 32'h0);
        chk({nm, "_vol"},    32'(SOUND_VOLUME),   32'hF);
        chk({nm, "_active"}, 32'(SFX_ACTIVE),     32'h0);
        chk({nm, "_start"},  32'(SFX_START),      32'h0);
        chk({nm, "_id"},     32'(SFX_ID),         32'h0);
    endtask

    initial begin
        vec_t v;
        vec_t e;
        int   e1;
        int   e2;

        HRESETn = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HTRANS = 2'b00;

        //              addr         trans  wr    wdata          mus vol   act      start    id
        vecs[0]  = '{a_off(0),     2'b10, 1'b1, 32'h0000_0001, 1, 4'hF, 4'b0000, 4'b0000, 16'h0000};
        vecs[1]  = '{a_off(0),     2'b10, 1'b1, 32'h0000_0000, 0, 4'hF, 4'b0000, 4'b0000, 16'h0000};
        vecs[2]  = '{a_off(0),     2'b11, 1'b1, 32'h0000_0100, 1, 4'hF, 4'b0000, 4'b0000, 16'h0000};
        vecs[3]  = '{a_off(1),     2'b10, 1'b1, 32'h0000_0003, 1, 4'h3, 4'b0000, 4'b0000, 16'h0000};
        vecs[4]  = '{a_off(1),     2'b10, 1'b1, 32'hFFFF_FFF7, 1, 4'h7, 4'b0000, 4'b0000, 16'h0000};
        vecs[5]  = '{a_off(0),     2'b00, 1'b1, 32'h0000_0000, 1, 4'h7, 4'b0000, 4'b0000, 16'h0000};
        vecs[6]  = '{a_off(1),     2'b01, 1'b1, 32'h0000_0000, 1, 4'h7, 4'b0000, 4'b0000, 16'h0000};
        vecs[7]  = '{a_off(6),     2'b10, 1'b1, 32'h0000_0000, 1, 4'h7, 4'b0000, 4'b0000, 16'h0000};
        vecs[8]  = '{32'h0000_0000, 2'b10, 1'b1, 32'h0000_0000, 1, 4'h7, 4'b0000, 4'b0000, 16'h0000};
        vecs[9]  = '{a_off(2),     2'b10, 1'b1, 32'h0000_07FF, 1, 4'h7, 4'b0001, 4'b0001, 16'h0007};
        vecs[10] = '{a_off(5),     2'b10, 1'b1, 32'h0000_0AFF, 1, 4'h7, 4'b1001, 4'b1000, 16'hA007};
        vecs[11] = '{a_off(2),     2'b10, 1'b1, 32'h0000_0300, 1, 4'h7, 4'b1000, 4'b0000, 16'hA003};
        vecs[12] = '{a_off(5),     2'b10, 1'b1, 32'h0000_0000, 1, 4'h7, 4'b0000, 4'b0000, 16'h0003};
        vecs[13] = '{a_off(0),     2'b10, 1'b0, 32'h0000_0000, 1, 4'h7, 4'b0000, 4'b0000, 16'h0003};

        // Reset values while reset is held
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_state("reset_init");
        @(negedge CLK);
        HRESETn = 1'b1;

        // Table vectors through the scoreboard
        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            sb_q.push_back(v);
            ahb_xfer(v.addr, v.trans, v.write, v.wdata);
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_music", i),  32'(SOUND_MUSIC_EN), 32'(e.music));
            chk($sformatf("vec%0d_vol", i),    32'(SOUND_VOLUME),   32'(e.vol));
            chk($sformatf("vec%0d_active", i), 32'(SFX_ACTIVE),     32'(e.active));
            chk($sformatf("vec%0d_start", i),  32'(SFX_START),      32'(e.start));
            chk($sformatf("vec%0d_id", i),     32'(SFX_ID),         32'(e.id));
        end

        // Three-tick effect on ch0: single START, ID 5, exact active window
        ahb_xfer(a_off(2), 2'b10, 1'b1, 32'h0000_0503);
        e1 = edge_cnt;
        chk("sfx3_start", 32'(SFX_START[0]), 32'h1);
        chk("sfx3_id", 32'(SFX_ID[3:0]), 32'h5);
        chk("sfx3_active", 32'(SFX_ACTIVE[0]), 32'h1);
        @(posedge CLK);
        #1;
        chk("sfx3_start_drop", 32'(SFX_START[0]), 32'h0);
        measure(0, exp_fall(e1, 3) - 1, "sfx3_duration");

        // Stop an active ch1 with a zero-duration write
        ahb_xfer(a_off(3), 2'b10, 1'b1, 32'h0000_0902);
        chk("stop_pre_active", 32'(SFX_ACTIVE[1]), 32'h1);
        ahb_xfer(a_off(3), 2'b10, 1'b1, 32'h0000_0200);
        chk("stop_active", 32'(SFX_ACTIVE[1]), 32'h0);
        chk("stop_start", 32'(SFX_START[1]), 32'h0);
        chk("stop_id", 32'(SFX_ID[7:4]), 32'h2);

        // Reload ch0 on the very edge its last tick would expire it
        begin : align
            int guard = 0;
            @(posedge CLK);
            #1;
            while (edge_cnt % TDIV != 0 && guard < 10) begin
                @(posedge CLK);
                #1;
                guard++;
            end
        end
        ahb_xfer(a_off(2), 2'b10, 1'b1, 32'h0000_0101);
        e1 = edge_cnt;
        chk("race_pre_active", 32'(SFX_ACTIVE[0]), 32'h1);
        ahb_xfer(a_off(2), 2'b10, 1'b1, 32'h0000_0C02);
        e2 = edge_cnt;
        chk("race_active", 32'(SFX_ACTIVE[0]), 32'h1);
        chk("race_start", 32'(SFX_START[0]), 32'h1);
        chk("race_id", 32'(SFX_ID[3:0]), 32'hC);
        chk("race_edge_gap", 32'(e2 - e1), 32'h2);
        measure(0, exp_fall(e2, 2), "race_duration");

        // Reset in the middle of playback
        ahb_xfer(a_off(4), 2'b10, 1'b1, 32'h0000_09FF);
        chk("mid_active", 32'(SFX_ACTIVE[2]), 32'h1);
        @(negedge CLK);
        HRESETn = 1'b0;
        #1;
        chk_reset_state("reset_mid");
        @(negedge CLK);
        HRESETn = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_reset_start", 32'(SFX_START), 32'h0);
        chk("post_reset_active", 32'(SFX_ACTIVE), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop so the run cannot hang
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
